// File: rtl/vector_to_axis_pkt.sv
`default_nettype none
// ============================================================================
// vector_to_axis_pkt : byte vector + runtime length -> one AXI-stream packet
// Revision: 1.0
// ============================================================================
module vector_to_axis_pkt #(
  parameter int VEC_BYTES  = 16,
  parameter int AXIS_BYTES = 4,
  parameter int MSB_FIRST  = 0,
  parameter int REPEAT     = 0
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  input  logic [VEC_BYTES*8-1:0]         in_vec,
  input  logic [$clog2(VEC_BYTES+1)-1:0] in_len,
  input  logic                           axis_tready,
  output logic                           axis_tvalid,
  output logic                           axis_tlast,
  output logic [AXIS_BYTES-1:0]          axis_tkeep,
  output logic [AXIS_BYTES*8-1:0]        axis_tdata
);

  localparam int c_beats  = VEC_BYTES / AXIS_BYTES;
  localparam int c_ctr_w  = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_len_w  = $clog2(VEC_BYTES + 1);
  localparam int c_rem_w  = $clog2(AXIS_BYTES + 1);
  localparam int c_lane_w = AXIS_BYTES * 8;

  generate
    if (VEC_BYTES % AXIS_BYTES != 0) begin : g_param_check
      $error("VEC_BYTES must be a multiple of AXIS_BYTES");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [c_ctr_w-1:0]     ctr_q, ctr_d;
  logic [c_ctr_w-1:0]     last_q, last_d;
  logic [c_rem_w-1:0]     rem_q, rem_d;
  logic [VEC_BYTES*8-1:0] vec_q, vec_d;

  logic [c_len_w-1:0]     w_len;
  logic [c_ctr_w-1:0]     w_last;
  logic [c_rem_w-1:0]     w_rem;
  logic [c_ctr_w-1:0]     w_chunk_idx;
  logic [c_lane_w-1:0]    w_chunk;
  logic [AXIS_BYTES-1:0]  w_keep;
  logic                   w_out_hs;
  logic                   w_in_hs;

  // Out-of-range lengths (0 or > VEC_BYTES) mean a full vector.
  always_comb begin
    w_len = in_len;
    if (in_len == '0 || int'(in_len) > VEC_BYTES) begin
      w_len = c_len_w'(VEC_BYTES);
    end
    w_last = c_ctr_w'((int'(w_len) - 1) / AXIS_BYTES);
    w_rem  = c_rem_w'(int'(w_len) - int'(w_last) * AXIS_BYTES);
  end

  assign axis_tvalid = (state_q == ST_SEND);
  assign axis_tlast  = axis_tvalid && (ctr_q == last_q);
  assign w_out_hs    = axis_tvalid & axis_tready;
  // A new vector is only taken while idle or on the final-beat handshake.
  assign in_tready   = aresetn & ((state_q == ST_IDLE) | (w_out_hs & axis_tlast));
  assign w_in_hs     = in_tvalid & in_tready;

  always_comb begin
    w_chunk_idx = (MSB_FIRST != 0) ? (c_ctr_w'(c_beats - 1) - ctr_q) : ctr_q;
    w_chunk     = '0;
    for (int j = 0; j < c_beats; j++) begin
      if (int'(w_chunk_idx) == j) begin
        w_chunk = vec_q[j*c_lane_w +: c_lane_w];
      end
    end
    w_keep = '0;
    for (int i = 0; i < AXIS_BYTES; i++) begin
      if (!axis_tlast) begin
        w_keep[i] = 1'b1;
      end else if (MSB_FIRST != 0) begin
        w_keep[i] = (i >= AXIS_BYTES - int'(rem_q));
      end else begin
        w_keep[i] = (i < int'(rem_q));
      end
    end
    axis_tkeep = '0;
    axis_tdata = '0;
    for (int i = 0; i < AXIS_BYTES; i++) begin
      axis_tkeep[i]       = axis_tvalid & w_keep[i];
      axis_tdata[i*8 +: 8] = (axis_tvalid && w_keep[i]) ? w_chunk[i*8 +: 8] : 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    last_d  = last_q;
    rem_d   = rem_q;
    vec_d   = vec_q;
    if (w_in_hs) begin
      vec_d   = in_vec;
      last_d  = w_last;
      rem_d   = w_rem;
      ctr_d   = '0;
      state_d = ST_SEND;
    end else if (w_out_hs) begin
      if (!axis_tlast) begin
        ctr_d = ctr_q + c_ctr_w'(1);
      end else if (REPEAT != 0) begin
        ctr_d = '0;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      vec_q   <= vec_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_to_axis_pkt.sv
`default_nettype none
// ============================================================================
// tb_vector_to_axis_pkt : directed bench for vector_to_axis_pkt (three configs)
// Revision: 1.0
// ============================================================================
module tb_vector_to_axis_pkt;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         in_tvalid = 1'b0;
  logic [127:0] in_vec = '0;
  logic [4:0]   in_len = '0;
  logic         axis_tready = 1'b1;

  logic        rdy [3];
  logic        tv  [3];
  logic        tl  [3];
  logic [3:0]  tk  [3];
  logic [31:0] td  [3];

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] c_v1 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] c_v2 = 128'h1F1E1D1C1B1A19181716151413121110;

  always #5 clk = ~clk;

  // dut 0: LSB-first one-shot, dut 1: MSB-first one-shot, dut 2: LSB-first repeat
  vector_to_axis_pkt #(.VEC_BYTES(16), .AXIS_BYTES(4), .MSB_FIRST(0), .REPEAT(0)) u_dut0 (
    .clk(clk), .aresetn(aresetn), .in_tvalid(in_tvalid), .in_tready(rdy[0]),
    .in_vec(in_vec), .in_len(in_len), .axis_tready(axis_tready), .axis_tvalid(tv[0]),
    .axis_tlast(tl[0]), .axis_tkeep(tk[0]), .axis_tdata(td[0]));
  vector_to_axis_pkt #(.VEC_BYTES(16), .AXIS_BYTES(4), .MSB_FIRST(1), .REPEAT(0)) u_dut1 (
    .clk(clk), .aresetn(aresetn), .in_tvalid(in_tvalid), .in_tready(rdy[1]),
    .in_vec(in_vec), .in_len(in_len), .axis_tready(axis_tready), .axis_tvalid(tv[1]),
    .axis_tlast(tl[1]), .axis_tkeep(tk[1]), .axis_tdata(td[1]));
  vector_to_axis_pkt #(.VEC_BYTES(16), .AXIS_BYTES(4), .MSB_FIRST(0), .REPEAT(1)) u_dut2 (
    .clk(clk), .aresetn(aresetn), .in_tvalid(in_tvalid), .in_tready(rdy[2]),
    .in_vec(in_vec), .in_len(in_len), .axis_tready(axis_tready), .axis_tvalid(tv[2]),
    .axis_tlast(tl[2]), .axis_tkeep(tk[2]), .axis_tdata(td[2]));

  typedef struct packed {
    logic [4:0]        len;
    logic [2:0]        nb;
    logic [3:0][31:0]  d0;
    logic [3:0][3:0]   k0;
    logic [3:0][31:0]  d1;
    logic [3:0][3:0]   k1;
  } pkt_t;

  pkt_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{len: 5'd16, nb: 3'd4,
               d0: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}, k0: 16'hFFFF,
               d1: {32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C}, k1: 16'hFFFF};
    tbl[1] = '{len: 5'd6, nb: 3'd2,
               d0: {32'h0, 32'h0, 32'h00000504, 32'h03020100}, k0: 16'h003F,
               d1: {32'h0, 32'h0, 32'h0B0A0000, 32'h0F0E0D0C}, k1: 16'h00CF};
    tbl[2] = tbl[0];
    tbl[2].len = 5'd0;
    tbl[3] = '{len: 5'd5, nb: 3'd2,
               d0: {32'h0, 32'h0, 32'h00000004, 32'h03020100}, k0: 16'h001F,
               d1: {32'h0, 32'h0, 32'h0B000000, 32'h0F0E0D0C}, k1: 16'h008F};
    tbl[4] = '{len: 5'd4, nb: 3'd1,
               d0: {32'h0, 32'h0, 32'h0, 32'h03020100}, k0: 16'h000F,
               d1: {32'h0, 32'h0, 32'h0, 32'h0F0E0D0C}, k1: 16'h000F};
    tbl[5] = tbl[0];
    tbl[5].len = 5'd20;
    tbl[6] = '{len: 5'd9, nb: 3'd3,
               d0: {32'h0, 32'h00000008, 32'h07060504, 32'h03020100}, k0: 16'h01FF,
               d1: {32'h0, 32'h07000000, 32'h0B0A0908, 32'h0F0E0D0C}, k1: 16'h08FF};

    // reset state
    @(negedge clk);
    chk("rst_tvalid", tv[0], 0);
    chk("rst_tlast", tl[0], 0);
    chk("rst_tkeep", tk[0], 0);
    chk("rst_tdata", td[0], 0);
    chk("rst_in_tready", rdy[0], 0);
    aresetn = 1'b1;
    #1;
    chk("post_rst_in_tready", rdy[0], 1);
    @(negedge clk);

    // table-driven single packets, dut0 and dut1 in lock-step
    for (int p = 0; p < 7; p++) begin
      chk("idle_in_tready", rdy[0], 1);
      in_vec = c_v1;
      in_len = tbl[p].len;
      in_tvalid = 1'b1;
      chk("load_cycle_tvalid", tv[0], 0);
      @(negedge clk);
      in_tvalid = 1'b0;
      in_vec = '1;
      in_len = 5'd3;
      for (int b = 0; b < int'(tbl[p].nb); b++) begin
        chk("tbl_tvalid0", tv[0], 1);
        chk("tbl_tdata0", td[0], tbl[p].d0[b]);
        chk("tbl_tkeep0", tk[0], tbl[p].k0[b]);
        chk("tbl_tlast0", tl[0], (b == int'(tbl[p].nb) - 1));
        chk("tbl_tdata1", td[1], tbl[p].d1[b]);
        chk("tbl_tkeep1", tk[1], tbl[p].k1[b]);
        chk("tbl_tlast1", tl[1], (b == int'(tbl[p].nb) - 1));
        @(negedge clk);
      end
      chk("tbl_end_tvalid", tv[0], 0);
      chk("tbl_end_in_tready", rdy[0], 1);
    end

    // backpressure with a pending vector, then zero-bubble reload
    in_vec = c_v1; in_len = 5'd16; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("bp_beat0", td[0], 32'h03020100);
    @(negedge clk);
    in_vec = c_v2; in_len = 5'd16; in_tvalid = 1'b1; axis_tready = 1'b0;
    repeat (5) begin
      chk("bp_hold_tdata", td[0], 32'h07060504);
      chk("bp_hold_tkeep", tk[0], 32'hF);
      chk("bp_hold_tlast", tl[0], 0);
      chk("bp_hold_in_tready", rdy[0], 0);
      @(negedge clk);
    end
    axis_tready = 1'b1;
    chk("bp_beat1", td[0], 32'h07060504);
    @(negedge clk);
    chk("bp_beat2", td[0], 32'h0B0A0908);
    chk("bp_beat2_in_tready", rdy[0], 0);
    @(negedge clk);
    chk("bp_beat3", td[0], 32'h0F0E0D0C);
    chk("bp_beat3_tlast", tl[0], 1);
    chk("bp_beat3_in_tready", rdy[0], 1);
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("b2b_tvalid", tv[0], 1);
    chk("b2b_beat0", td[0], 32'h13121110);
    chk("b2b_beat0_msb", td[1], 32'h1F1E1D1C);
    chk("b2b_tlast", tl[0], 0);
    @(negedge clk);
    chk("b2b_beat1", td[0], 32'h17161514);
    @(negedge clk);
    chk("b2b_beat2", td[0], 32'h1B1A1918);
    @(negedge clk);
    chk("b2b_beat3", td[0], 32'h1F1E1D1C);
    chk("b2b_beat3_tlast", tl[0], 1);
    @(negedge clk);
    chk("b2b_idle", tv[0], 0);

    // repeat mode
    pulse_reset();
    in_vec = c_v1; in_len = 5'd8; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("rep_tvalid", tv[2], 1);
      chk("rep_tdata", td[2], (k % 2 != 0) ? 32'h07060504 : 32'h03020100);
      chk("rep_tlast", tl[2], (k % 2 != 0));
      @(negedge clk);
    end
    in_vec = c_v2; in_len = 5'd8; in_tvalid = 1'b1;
    chk("rep_pend_tdata", td[2], 32'h03020100);
    chk("rep_pend_in_tready", rdy[2], 0);
    @(negedge clk);
    chk("rep_pend_last", td[2], 32'h07060504);
    chk("rep_pend_in_tready_last", rdy[2], 1);
    @(negedge clk);
    in_tvalid = 1'b0;
    chk("rep_new0", td[2], 32'h13121110);
    @(negedge clk);
    chk("rep_new1", td[2], 32'h17161514);
    @(negedge clk);
    chk("rep_new_again", td[2], 32'h13121110);

    // asynchronous reset mid-packet
    pulse_reset();
    in_vec = c_v1; in_len = 5'd16; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    @(negedge clk);
    chk("arst_pre_tdata", td[0], 32'h07060504);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", tv[0], 0);
    chk("arst_tlast", tl[0], 0);
    chk("arst_tkeep", tk[0], 0);
    chk("arst_tdata", td[0], 0);
    chk("arst_in_tready", rdy[0], 0);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("arst_rel_in_tready", rdy[0], 1);
    chk("arst_rel_tvalid", tv[0], 0);
    @(negedge clk);
    in_vec = c_v1; in_len = 5'd16; in_tvalid = 1'b1;
    @(negedge clk);
    in_tvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("arst_fresh_tdata", td[0], tbl[0].d0[b]);
      chk("arst_fresh_tlast", tl[0], (b == 3));
      @(negedge clk);
    end
    chk("arst_fresh_end", tv[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_to_axis_pkt.md
Name: vector_to_axis_pkt

Overview:
- Parametrised successor to the free-running vector streamer.
- Accepts a byte vector plus a runtime byte length on an input handshake, then emits it as one AXI-stream packet with tkeep on the final partial beat.
- Optional REPEAT mode replays the held vector until a new one is loaded.
- Sits between register/config logic and AXIS packet sinks, e.g. header inserters and test pattern sources.

Parameters:
- VEC_BYTES, 16: bytes in the input vector. Must be a multiple of AXIS_BYTES; violation is an elaboration-time error.
- AXIS_BYTES, 4: output data width in bytes.
- MSB_FIRST, 0: 0 streams vec byte 0 first; 1 streams vec byte VEC_BYTES-1 first.
- REPEAT, 0: 0 sends each loaded vector once; 1 replays the held vector back-to-back.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- in_tvalid  in  1  vector/length valid
- in_tready  out  1  vector accepted when in_tvalid & in_tready
- in_vec  in  VEC_BYTES*8  vector to send
- in_len  in  $clog2(VEC_BYTES+1)  valid byte count. 0 or >VEC_BYTES means VEC_BYTES.
- axis_tready  in  1  downstream ready
- axis_tvalid  out  1  output valid
- axis_tlast  out  1  final beat of packet
- axis_tkeep  out  AXIS_BYTES  byte lane enables
- axis_tdata  out  AXIS_BYTES*8  data; lane i = bits [8i+7:8i]

Behaviour:
- Reset: one clock, async active-low. While aresetn=0:
  - State = IDLE; beat ctr = 0; held vec/len = 0.
  - axis_tvalid = 0, axis_tlast = 0, axis_tkeep = 0, axis_tdata = 0, in_tready = 0.
  - First cycle after release: in_tready = 1.
- Length decode at load: L = (in_len==0 || in_len>VEC_BYTES) ? VEC_BYTES : in_len. Beats N = ceil(L/AXIS_BYTES). Latch last-beat byte count R = L - (N-1)*AXIS_BYTES, range 1..AXIS_BYTES.
- States: IDLE, SEND.
  - IDLE: in_tready = 1, axis_tvalid = 0. On input handshake: latch vec and L, set ctr = 0, go to SEND. axis_tvalid rises the next cycle (1-cycle latency).
  - SEND: axis_tvalid = 1. Outputs are registered or derived only from state/ctr/held data; they never change while axis_tvalid & !axis_tready.
  - SEND, on each output handshake with ctr < N-1: ctr++.
- SEND, on output handshake with ctr == N-1 (tlast):
  - If in_tvalid: load the new vector (in_tready is 1 this cycle), ctr = 0, stay in SEND. Zero-bubble back-to-back.
  - Else if REPEAT=1: ctr = 0, stay in SEND, replay the held vector with no bubble.
  - Else: go to IDLE.
- in_tready in SEND = axis_tvalid & axis_tready & axis_tlast. This is a combinational path from axis_tready; it is documented and permitted. in_tready = 0 on all other SEND cycles.
- axis_tlast = (ctr == N-1) while in SEND.
- Data mapping, beat k, lane i:
  - MSB_FIRST=0: vec byte k*AXIS_BYTES + i.
  - MSB_FIRST=1: vec byte VEC_BYTES - (k+1)*AXIS_BYTES + i, i.e. chunks taken from the top with natural lane order inside each chunk.
- tkeep:
  - All ones on non-final beats.
  - Final beat, MSB_FIRST=0: lanes 0..R-1 set.
  - Final beat, MSB_FIRST=1: lanes AXIS_BYTES-R..AXIS_BYTES-1 set. The valid bytes are the top L bytes of vec.
  - Lanes with tkeep=0 drive tdata = 0.
- A change on in_vec/in_len without a handshake has no effect on the packet in flight.
- Reset asserted mid-packet: output drops immediately (tvalid=0); the packet is abandoned with no tlast. After release, the block is in IDLE.
- Degenerate N=1 (L ≤ AXIS_BYTES): every beat is tlast.
- ctr width: $clog2(VEC_BYTES/AXIS_BYTES), minimum 1.

Test Plan:
1. VEC_BYTES=16, AXIS_BYTES=4, MSB_FIRST=0. Load vec=0x0F0E..0100, len=16, tready=1 -> 4 beats: tdata 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. tkeep=0xF on every beat; tlast only on beat 4. axis_tvalid first high 1 cycle after load; in_tready returns to 1 in IDLE after the last beat.
2. Same vec, len=6 -> 2 beats: 0x03020100 tkeep=0xF, then 0x00000504 tkeep=0x3 with tlast. len=0 -> behaves as len=16.
3. MSB_FIRST=1, same vec, len=6 -> beats 0x0F0E0D0C tkeep=0xF, then 0x0B0A0000 tkeep=0xC with tlast.
4. Backpressure: hold axis_tready=0 for 5 cycles mid-packet -> tdata/tkeep/tlast stable, ctr frozen. in_tvalid held high throughout -> in_tready stays 0 until the tlast handshake, then the new vector's first beat appears the next cycle with no gap.
5. REPEAT=1, len=8, in_tvalid=0 after the first load -> continuous beats 0x03020100, 0x07060504(tlast), 0x03020100, ... with no idle cycles. Asserting in_tvalid with vec=0xAA.. -> new data begins right after the next tlast handshake.
6. Deassert aresetn mid-packet (beat 2 of 4) with no clock edge -> axis_tvalid, tlast and tkeep go 0 asynchronously. After release: IDLE, in_tready=1, a fresh load gives a full 4-beat packet starting at beat 0.
